// File: rtl/dbg_pkg.sv
// Shared definitions for the debug UART transmitter.
// Holds the FSM state encoding and the default bit period.
package dbg_pkg;

    localparam int DBG_CLK_DIV_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } dbg_state_e;

    // Counter width for a range of `value` states, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/dbg_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 and pulses bit_done on the last cycle.
// clear holds the count at zero so every bit period starts from a known phase.
module dbg_baud_gen
    import dbg_pkg::*;
#(
    parameter int CLK_DIV = DBG_CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int            CW   = clog2_min1(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        bit_done = !clear && (cnt_q == LAST);
        cnt_d    = cnt_q + CW'(1);
        if (clear || bit_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dbg_uart_tx.sv
// Debug UART transmitter: pops one word from the upstream debug FIFO and sends it
// as start bit, SIZE data bits LSB first, stop bit. Frames run back-to-back while data waits.
module dbg_uart_tx
    import dbg_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int CLK_DIV = DBG_CLK_DIV_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fifo_empty,
    output logic            fifo_rd_en,
    input  logic [SIZE-1:0] fifo_dout,
    output logic            tx,
    output logic            busy
);

    localparam int            IW       = clog2_min1(SIZE);
    localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

    dbg_state_e      state_q, state_d;
    logic [SIZE-1:0] shreg_q, shreg_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            rd_en_q, rd_en_d;
    logic            baud_clear;
    logic            bit_done;

    // The bit timer only runs while a frame is on the line.
    assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_FETCH) || (state_q == ST_LOAD);

    dbg_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (baud_clear),
        .bit_done (bit_done)
    );

    always_comb begin
        // NOTE: every _d is given its hold value first so no branch can leave it unassigned and infer a latch.
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shreg_d = fifo_dout;
                idx_d   = '0;
                state_d = ST_START;
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_d = fifo_empty ? ST_IDLE : ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // tx is a registered decode of the current state, so the line trails the
        // state by one cycle: the start bit falls on the third edge after the pop request.
        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_q[idx_q];
            default:  tx_d = 1'b1;
        endcase

        busy_d  = (state_d != ST_IDLE);
        rd_en_d = (state_d == ST_FETCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            rd_en_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values, independent of statement order.
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            rd_en_q <= rd_en_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_rd_en = rd_en_q;

endmodule
